reg_hazard_scoreboard: RTL and testbench
========================================

Name: reg_hazard_scoreboard

Overview:
- Issue-side RAW hazard detector between decode and the register-file read stage.
- Tracks outstanding writes per GPR (32 Power ISA GPRs; r0 is a real register).
- Holds one decoded instruction and drives regFileStall_o, the register-file stall request into the stall unit, which then full-stalls fetch/decode.
- Releases the instruction when its sources are clean.

Parameters:
NUM_REGS, 32, number of tracked GPRs
REG_IDX_W, 5, register index width
CNT_W, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_W-1 = 3

Ports:
clock_i  in  1  system clock, all state updates on posedge
reset_i  in  1  synchronous, active-high reset
instrValid_i  in  1  decoded instruction presented
srcA_i / srcB_i / srcC_i  in  REG_IDX_W each  source register indices
srcAValid_i / srcBValid_i / srcCValid_i  in  1 each  source used
dest_i  in  REG_IDX_W  destination register index
destValid_i  in  1  instruction writes dest_i
wbValid_i  in  1  writeback of one register this cycle
wbReg_i  in  REG_IDX_W  writeback register index
flush_i  in  1  discard held instruction
instrReady_o  out  1  hold register can accept this cycle
issueValid_o  out  1  held instruction issues this cycle
issueDest_o  out  REG_IDX_W  dest of issuing instruction
regFileStall_o  out  1  stall request to stall unit
wbUnderflow_o  out  1  sticky: writeback to a register with count 0

Behaviour:
- Reset: all counters 0, hold register empty, all outputs 0, wbUnderflow_o cleared.
- Hold register: loads inputs at posedge when instrValid_i && instrReady_o. instrReady_o = !holdValid || issueValid_o.
- Hazard (combinational from registered state), any of:
  - a valid source has count != 0
  - destValid && count[dest] == 3 (saturation, structural)
- regFileStall_o = holdValid && hazard. Combinational from registers only, stable before negedge, so the stall unit samples it the same cycle.
- issueValid_o = holdValid && !hazard. issueDest_o = held dest when issuing, else 0.
- Issue with destValid: count[dest] += 1 at posedge.
- Writeback, wbValid_i: count[wbReg_i] -= 1 at posedge.
  - Same reg issued and written back in the same cycle: net unchanged.
  - Writeback with count 0: counter stays 0, wbUnderflow_o set to 1 until reset.
- Latency:
  - Clean instruction issues the cycle after capture (1-cycle).
  - Stalled instruction issues the cycle after the last conflicting writeback (no same-cycle bypass unless the optional feature is enabled).
- Upstream contract: while regFileStall_o=1, upstream holds instrValid_i; input is ignored when instrReady_o=0.
- flush_i: hold register emptied at posedge; counters untouched (in-flight writes still write back). A flush and a capture in the same cycle: flush wins, new instruction is dropped.
- Reset mid-stall: hold cleared, stall drops the next cycle.
- Duplicate sources (srcA==srcB) are legal. A source equal to the dest checks the pre-issue count.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - A writeback in the current cycle to a source register whose count is 1 is treated as clean, so the instruction issues that same cycle.
  - The saturation check also treats a same-cycle writeback to dest as freeing one slot.
- Undefined: hazard uses registered counts only.

Decomposition:
- Shared package:
  - NUM_REGS, REG_IDX_W, CNT_W constants
  - CNT_MAX constant
  - counter typedef
  - held-instruction struct typedef (srcs, valids, dest, destValid)
- Sub-module reg_pending_counter: array of NUM_REGS counters with one increment port and one decrement port, count read-out per register, and underflow flag.
- Hazard compare and hold register live in the top.

Test Plan:
- Reset, then issue add r3<-r1,r2 with all counts 0 -> issueValid_o=1 the cycle after capture, regFileStall_o=0, count[r3]=1.
- Issue writer of r5, then a reader of r5; wbReg_i=5 two cycles later -> regFileStall_o=1 until the wb cycle, issueValid_o=1 the cycle after wb, count[r5]=0.
- Four back-to-back writers of r7 with no wb -> first three issue, fourth stalls (count=3) until one wbReg_i=7 arrives.
- Issue to r9 and wb to r9 in the same cycle with count[r9]=1 -> count stays 1; wb to r10 with count 0 -> wbUnderflow_o=1, count stays 0.
- Stalled reader, then flush_i=1 -> next cycle regFileStall_o=0, instrReady_o=1, counters unchanged. Repeat with reset_i=1 mid-stall -> all outputs 0 next cycle.
- With SCOREBOARD_WB_BYPASS_EN: reader of r4 with count=1 and wbReg_i=4 in the same cycle -> issueValid_o=1 that cycle, regFileStall_o=0.

Source files
------------

// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared constants and types for the GPR read-after-write hazard scoreboard.
// Used by reg_hazard_scoreboard and reg_pending_counter.
package reg_hazard_scoreboard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;

    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam cnt_t CNT_MAX = '1;

    typedef struct packed {
        reg_idx_t src_a;
        reg_idx_t src_b;
        reg_idx_t src_c;
        logic     src_a_valid;
        logic     src_b_valid;
        logic     src_c_valid;
        reg_idx_t dest;
        logic     dest_valid;
    } held_instr_t;

endpackage

// File: rtl/reg_hazard_scoreboard_pending_counter.sv
// reg_pending_counter: one saturating pending-write counter per GPR, with one
// increment (issue) port, one decrement (writeback) port and a sticky underflow flag.
module reg_pending_counter
    import reg_hazard_scoreboard_pkg::*;
(
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                incValid_i,
    input  logic [REG_IDX_W-1:0]                incReg_i,
    input  logic                                decValid_i,
    input  logic [REG_IDX_W-1:0]                decReg_i,
    output logic [NUM_REGS-1:0][CNT_W-1:0]      counts_o,
    output logic                                underflow_o
);

    logic [NUM_REGS-1:0][CNT_W-1:0] r_count;
    logic                           r_underflow;
    logic [NUM_REGS-1:0]            w_inc;
    logic [NUM_REGS-1:0]            w_dec;
    logic                           w_dec_underflow;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_inc[i] = incValid_i && (incReg_i == REG_IDX_W'(i));
            w_dec[i] = decValid_i && (decReg_i == REG_IDX_W'(i));
        end
        // A writeback paired with an issue to the same register cancels out.
        w_dec_underflow = decValid_i && !(incValid_i && (incReg_i == decReg_i))
                          && (r_count[decReg_i] == '0);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i] && (r_count[i] != CNT_MAX)) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && (r_count[i] != '0)) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end
            end
            if (w_dec_underflow) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign counts_o    = r_count;
    assign underflow_o = r_underflow;

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Issue-side RAW hazard scoreboard: holds one decoded instruction and stalls it until its GPR sources are clean.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear the last pending write.
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 instrValid_i,
    input  logic [REG_IDX_W-1:0] srcA_i,
    input  logic [REG_IDX_W-1:0] srcB_i,
    input  logic [REG_IDX_W-1:0] srcC_i,
    input  logic                 srcAValid_i,
    input  logic                 srcBValid_i,
    input  logic                 srcCValid_i,
    input  logic [REG_IDX_W-1:0] dest_i,
    input  logic                 destValid_i,
    input  logic                 wbValid_i,
    input  logic [REG_IDX_W-1:0] wbReg_i,
    input  logic                 flush_i,
    output logic                 instrReady_o,
    output logic                 issueValid_o,
    output logic [REG_IDX_W-1:0] issueDest_o,
    output logic                 regFileStall_o,
    output logic                 wbUnderflow_o
);

    // Handshake: an instruction transfers at posedge when instrValid_i && instrReady_o;
    // upstream keeps instrValid_i and its fields steady while instrReady_o is low.

    held_instr_t                    r_hold;
    logic                           r_hold_valid;
    logic                           r_active;
    logic [NUM_REGS-1:0][CNT_W-1:0] w_counts;
    cnt_t                           w_cnt_a;
    cnt_t                           w_cnt_b;
    cnt_t                           w_cnt_c;
    cnt_t                           w_cnt_d;
    logic                           w_free_a;
    logic                           w_free_b;
    logic                           w_free_c;
    logic                           w_free_d;
    logic                           w_hazard;
    logic                           w_issue;
    logic                           w_accept;

    reg_pending_counter u_counter (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .incValid_i  (w_issue && r_hold.dest_valid),
        .incReg_i    (r_hold.dest),
        .decValid_i  (wbValid_i),
        .decReg_i    (wbReg_i),
        .counts_o    (w_counts),
        .underflow_o (wbUnderflow_o)
    );

    always_comb begin
        w_cnt_a = w_counts[r_hold.src_a];
        w_cnt_b = w_counts[r_hold.src_b];
        w_cnt_c = w_counts[r_hold.src_c];
        w_cnt_d = w_counts[r_hold.dest];
`ifdef SCOREBOARD_WB_BYPASS_EN
        w_free_a = wbValid_i && (wbReg_i == r_hold.src_a) && (w_cnt_a == cnt_t'(1));
        w_free_b = wbValid_i && (wbReg_i == r_hold.src_b) && (w_cnt_b == cnt_t'(1));
        w_free_c = wbValid_i && (wbReg_i == r_hold.src_c) && (w_cnt_c == cnt_t'(1));
        w_free_d = wbValid_i && (wbReg_i == r_hold.dest);
`else
        w_free_a = 1'b0;
        w_free_b = 1'b0;
        w_free_c = 1'b0;
        w_free_d = 1'b0;
`endif
        // Saturated dest is a structural hazard: the counter has no room for another write.
        w_hazard = (r_hold.src_a_valid && (w_cnt_a != '0) && !w_free_a)
                || (r_hold.src_b_valid && (w_cnt_b != '0) && !w_free_b)
                || (r_hold.src_c_valid && (w_cnt_c != '0) && !w_free_c)
                || (r_hold.dest_valid  && (w_cnt_d == CNT_MAX) && !w_free_d);
        w_issue  = r_hold_valid && !w_hazard;
    end

    // r_active keeps instrReady_o low for the cycle after reset so every output reads 0 there.
    assign instrReady_o   = r_active && (!r_hold_valid || w_issue);
    assign issueValid_o   = w_issue;
    assign issueDest_o    = w_issue ? r_hold.dest : '0;
    assign regFileStall_o = r_hold_valid && w_hazard;
    assign w_accept       = instrValid_i && instrReady_o;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_active     <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (flush_i) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_valid       <= 1'b1;
                r_hold.src_a       <= srcA_i;
                r_hold.src_b       <= srcB_i;
                r_hold.src_c       <= srcC_i;
                r_hold.src_a_valid <= srcAValid_i;
                r_hold.src_b_valid <= srcBValid_i;
                r_hold.src_c_valid <= srcCValid_i;
                r_hold.dest        <= dest_i;
                r_hold.dest_valid  <= destValid_i;
            end else if (w_issue) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Self-checking bench for reg_hazard_scoreboard; issued destinations are checked against an expected queue.
// Build with +define+SCOREBOARD_WB_BYPASS_EN to check the same-cycle writeback bypass timing.
`timescale 1ns/1ps
module tb_reg_hazard_scoreboard;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       instrValid_i = 1'b0;
    logic [4:0] srcA_i = '0, srcB_i = '0, srcC_i = '0;
    logic       srcAValid_i = 1'b0, srcBValid_i = 1'b0, srcCValid_i = 1'b0;
    logic [4:0] dest_i = '0;
    logic       destValid_i = 1'b0;
    logic       wbValid_i = 1'b0;
    logic [4:0] wbReg_i = '0;
    logic       flush_i = 1'b0;
    logic       instrReady_o, issueValid_o, regFileStall_o, wbUnderflow_o;
    logic [4:0] issueDest_o;

    int         checks = 0;
    int         errors = 0;
    int         n_wait;
    logic [4:0] exp_q[$];
    logic [4:0] exp_dest;

    reg_hazard_scoreboard dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .instrValid_i   (instrValid_i),
        .srcA_i         (srcA_i),
        .srcB_i         (srcB_i),
        .srcC_i         (srcC_i),
        .srcAValid_i    (srcAValid_i),
        .srcBValid_i    (srcBValid_i),
        .srcCValid_i    (srcCValid_i),
        .dest_i         (dest_i),
        .destValid_i    (destValid_i),
        .wbValid_i      (wbValid_i),
        .wbReg_i        (wbReg_i),
        .flush_i        (flush_i),
        .instrReady_o   (instrReady_o),
        .issueValid_o   (issueValid_o),
        .issueDest_o    (issueDest_o),
        .regFileStall_o (regFileStall_o),
        .wbUnderflow_o  (wbUnderflow_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Every issue seen on the bus must match the oldest expected destination.
    always @(negedge clock_i) begin
        if (issueValid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got dest %0d, nothing expected", issueDest_o);
            end else begin
                exp_dest = exp_q.pop_front();
                if (issueDest_o !== exp_dest) begin
                    errors++;
                    $display("FAIL issue_dest: got %0d expected %0d", issueDest_o, exp_dest);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic av, input logic [4:0] b, input logic bv,
                        input logic [4:0] c, input logic cv, input logic [4:0] d, input logic dv,
                        output int waited);
        logic rdy;
        bit   done;
        done = 0;
        waited = 0;
        srcA_i = a; srcAValid_i = av;
        srcB_i = b; srcBValid_i = bv;
        srcC_i = c; srcCValid_i = cv;
        dest_i = d; destValid_i = dv;
        instrValid_i = 1'b1;
        #1;
        for (int k = 0; k < 50 && !done; k++) begin
            rdy = instrReady_o;
            cyc();
            waited++;
            if (rdy === 1'b1) done = 1;
        end
        instrValid_i = 1'b0;
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: instruction not accepted in %0d cycles", waited);
        end
    endtask

    task automatic wb_pulse(input logic [4:0] r);
        wbValid_i = 1'b1;
        wbReg_i = r;
        cyc();
        wbValid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        instrValid_i = 1'b1;
        dest_i = 5'($urandom_range(0, 31));
        destValid_i = 1'b1;
        wbValid_i = 1'b1;
        wbReg_i = 5'($urandom_range(0, 31));
        cyc();
        cyc();
        reset_i = 1'b0; instrValid_i = 1'b0; destValid_i = 1'b0; wbValid_i = 1'b0;
        #1;
        checks++; if (instrReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", instrReady_o); end
        checks++; if (issueValid_o !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b expected 0", issueValid_o); end
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", regFileStall_o); end
        checks++; if (issueDest_o !== 5'd0) begin errors++; $display("FAIL reset_dest: got %0d expected 0", issueDest_o); end
        checks++; if (wbUnderflow_o !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", wbUnderflow_o); end
        cyc();
        checks++; if (instrReady_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", instrReady_o); end
    endtask

    task automatic test_clean_issue();
        exp_q.push_back(5'd3);
        send(5'd1, 1, 5'd2, 1, 5'd0, 0, 5'd3, 1, n_wait);
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL clean_issue: got %b expected 1", issueValid_o); end
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL clean_stall: got %b expected 0", regFileStall_o); end
        cyc();
        checks++; if (issueValid_o !== 1'b0) begin errors++; $display("FAIL clean_drained: got %b expected 0", issueValid_o); end
        // r3 now has one write pending, so a reader stalls until exactly one writeback
        exp_q.push_back(5'd0);
        send(5'd3, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL r3_reader_stall: got %b expected 1", regFileStall_o); end
        wb_pulse(5'd3);
        checks++; if (instrReady_o !== 1'b1) begin errors++; $display("FAIL r3_released: ready %b expected 1", instrReady_o); end
        cyc();
    endtask

    task automatic test_raw_stall();
        exp_q.push_back(5'd5);
        send(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd5, 1, n_wait);
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL r5_writer_issue: got %b expected 1", issueValid_o); end
        exp_q.push_back(5'd0);
        send(5'd5, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL r5_stall: got %b expected 1", regFileStall_o); end
        checks++; if (instrReady_o !== 1'b0) begin errors++; $display("FAIL r5_ready_low: got %b expected 0", instrReady_o); end
        cyc();
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL r5_stall_hold: got %b expected 1", regFileStall_o); end
        wbValid_i = 1'b1; wbReg_i = 5'd5;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL r5_bypass_issue: got %b expected 1", issueValid_o); end
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL r5_bypass_stall: got %b expected 0", regFileStall_o); end
`else
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL r5_wb_cycle_stall: got %b expected 1", regFileStall_o); end
`endif
        cyc();
        wbValid_i = 1'b0;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        checks++; if (issueValid_o !== 1'b0) begin errors++; $display("FAIL r5_after_bypass: got %b expected 0", issueValid_o); end
`else
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL r5_issue_after_wb: got %b expected 1", issueValid_o); end
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL r5_stall_after_wb: got %b expected 0", regFileStall_o); end
`endif
        cyc();
        exp_q.push_back(5'd0);
        send(5'd0, 0, 5'd0, 0, 5'd5, 1, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL r5_count_zero: stall %b expected 0", regFileStall_o); end
        cyc();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(5'd7);
            send(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd7, 1, n_wait);
            if (k < 3) begin
                checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL sat_writer%0d_issue: got %b expected 1", k, issueValid_o); end
            end
        end
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", regFileStall_o); end
        cyc();
        checks++; if (issueValid_o !== 1'b0) begin errors++; $display("FAIL sat_hold: got %b expected 0", issueValid_o); end
        wbValid_i = 1'b1; wbReg_i = 5'd7;
        #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL sat_bypass_issue: got %b expected 1", issueValid_o); end
`else
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL sat_wb_cycle_stall: got %b expected 1", regFileStall_o); end
`endif
        cyc();
        wbValid_i = 1'b0;
        #1;
`ifndef SCOREBOARD_WB_BYPASS_EN
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL sat_issue_after_wb: got %b expected 1", issueValid_o); end
`endif
        cyc();
        for (int k = 0; k < 3; k++) wb_pulse(5'd7);
        checks++; if (wbUnderflow_o !== 1'b0) begin errors++; $display("FAIL sat_drain_underflow: got %b expected 0", wbUnderflow_o); end
    endtask

    task automatic test_same_cycle();
        exp_q.push_back(5'd9);
        send(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd9, 1, n_wait);
        cyc();
        exp_q.push_back(5'd9);
        send(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd9, 1, n_wait);
        wbValid_i = 1'b1; wbReg_i = 5'd9;
        #1;
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL r9_issue_with_wb: got %b expected 1", issueValid_o); end
        cyc();
        wbValid_i = 1'b0;
        #1;
        // count[r9] must still be 1: one writeback releases a reader and does not underflow
        exp_q.push_back(5'd0);
        send(5'd9, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL r9_reader_stall: got %b expected 1", regFileStall_o); end
        wb_pulse(5'd9);
        checks++; if (instrReady_o !== 1'b1) begin errors++; $display("FAIL r9_released: ready %b expected 1", instrReady_o); end
        cyc();
        checks++; if (wbUnderflow_o !== 1'b0) begin errors++; $display("FAIL r9_no_underflow: got %b expected 0", wbUnderflow_o); end
        wb_pulse(5'd10);
        checks++; if (wbUnderflow_o !== 1'b1) begin errors++; $display("FAIL r10_underflow: got %b expected 1", wbUnderflow_o); end
        exp_q.push_back(5'd0);
        send(5'd0, 0, 5'd10, 1, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL r10_count_zero: issue %b expected 1", issueValid_o); end
        cyc();
        checks++; if (wbUnderflow_o !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", wbUnderflow_o); end
    endtask

    task automatic test_flush_reset();
        exp_q.push_back(5'd11);
        send(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd11, 1, n_wait);
        cyc();
        send(5'd11, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b expected 1", regFileStall_o); end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", regFileStall_o); end
        checks++; if (instrReady_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", instrReady_o); end
        // flush and capture together: the new instruction is dropped
        dest_i = 5'd12; destValid_i = 1'b1; srcAValid_i = 1'b0; instrValid_i = 1'b1; flush_i = 1'b1;
        cyc();
        instrValid_i = 1'b0; flush_i = 1'b0;
        #1;
        checks++; if (issueValid_o !== 1'b0) begin errors++; $display("FAIL flush_capture_drop: issue %b expected 0", issueValid_o); end
        send(5'd11, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (regFileStall_o !== 1'b1) begin errors++; $display("FAIL flush_counts_kept: stall %b expected 1", regFileStall_o); end
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        #1;
        checks++; if (regFileStall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", regFileStall_o); end
        checks++; if (instrReady_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", instrReady_o); end
        checks++; if (wbUnderflow_o !== 1'b0) begin errors++; $display("FAIL rst_mid_underflow: got %b expected 0", wbUnderflow_o); end
        cyc();
        exp_q.push_back(5'd0);
        send(5'd11, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, n_wait);
        checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL rst_counts_cleared: issue %b expected 1", issueValid_o); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [4:0] d;
        for (int k = 0; k < 8; k++) begin
            d = 5'($urandom_range(0, 31));
            exp_q.push_back(d);
            send(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), d, 1'b0, n_wait);
            checks++; if (n_wait != 1) begin errors++; $display("FAIL b2b_accept%0d: waited %0d expected 1", k, n_wait); end
            checks++; if (issueValid_o !== 1'b1) begin errors++; $display("FAIL b2b_issue%0d: got %b expected 1", k, issueValid_o); end
        end
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_clean_issue();
        test_raw_stall();
        test_saturation();
        test_same_cycle();
        test_flush_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain: %0d issues missing, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
